// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//   Issue/retire stage wrapped around a purely combinational ALU. Incoming ops
//   {src1, src2, ctrl} are buffered in a DEPTH-entry FIFO. The head entry is
//   driven onto the alu_* outputs. When the head can retire, the ALU outputs
//   are captured into a registered result slot that has a valid/ready handshake.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready        op handshake (in_ready depends only on state and rst)
//   in_src1/in_src2/in_ctrl  incoming op
//   alu_src1/src2/ctrl       head entry presented to the ALU (zeros when empty)
//   alu_result/zero/cout/overflow  combinational ALU response to alu_*
//   out_valid/out_ready      result slot handshake
//   out_result/out_zcv/out_ctrl    captured result, {zero,cout,overflow}, op code
//   count                    FIFO occupancy (result slot not included)
// -----------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_src1,
    input  logic [DATA_W-1:0]          in_src2,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic [DATA_W-1:0]          alu_src1,
    output logic [DATA_W-1:0]          alu_src2,
    output logic [CTRL_W-1:0]          alu_ctrl,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_zero,
    input  logic                       alu_cout,
    input  logic                       alu_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_result,
    output logic [2:0]                 out_zcv,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] src1_mem_r [DEPTH];
    logic [DATA_W-1:0] src2_mem_r [DEPTH];
    logic [CTRL_W-1:0] ctrl_mem_r [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_result_r;
    logic [2:0]        out_zcv_r;
    logic [CTRL_W-1:0] out_ctrl_r;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              not_empty_s;

    assign not_empty_s = (count_r != {CNT_W{1'b0}});

    // Accept side: depends only on registered occupancy and reset, never on out_ready.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (count_r != CNT_W'(DEPTH));
        end
    end

    // Transfer qualifiers; the head retires whenever the result slot is free or being drained.
    always_comb begin
        push_s = in_valid && in_ready_s;
        pop_s  = not_empty_s && (!out_valid_r || out_ready);
    end

    // Head entry to the ALU; all-zero (AND of zeros) while the FIFO is empty.
    always_comb begin
        alu_src1 = {DATA_W{1'b0}};
        alu_src2 = {DATA_W{1'b0}};
        alu_ctrl = {CTRL_W{1'b0}};
        if (not_empty_s) begin
            alu_src1 = src1_mem_r[rd_ptr_r];
            alu_src2 = src2_mem_r[rd_ptr_r];
            alu_ctrl = ctrl_mem_r[rd_ptr_r];
        end else begin
            alu_src1 = {DATA_W{1'b0}};
            alu_src2 = {DATA_W{1'b0}};
            alu_ctrl = {CTRL_W{1'b0}};
        end
    end

    // FIFO storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push_s) begin
            src1_mem_r[wr_ptr_r] <= in_src1;
            src2_mem_r[wr_ptr_r] <= in_src2;
            ctrl_mem_r[wr_ptr_r] <= in_ctrl;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Result slot: capture on pop, clear when drained with nothing behind it, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {DATA_W{1'b0}};
            out_zcv_r    <= 3'b000;
            out_ctrl_r   <= {CTRL_W{1'b0}};
        end else if (pop_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_result;
            out_zcv_r    <= {alu_zero, alu_cout, alu_overflow};
            out_ctrl_r   <= alu_ctrl;
        end else if (out_valid_r && out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_zcv    = out_zcv_r;
    assign out_ctrl   = out_ctrl_r;
    assign count      = count_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_queue
//   Directed vector table plus multi-cycle sequences for alu_issue_queue. A
//   behavioural ALU closes the loop from alu_* back to alu_result/flags.
// -----------------------------------------------------------------------------
module tb_alu_issue_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [3:0]  in_ctrl;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_cout;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_zcv;
    logic [3:0]  out_ctrl;
    logic [2:0]  count;

    alu_issue_queue #(.DATA_W(32), .CTRL_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_ctrl(in_ctrl),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zcv(out_zcv), .out_ctrl(out_ctrl),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, cout, overflow, result}.
    function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        r  = 32'd0;
        co = 1'b0;
        ov = 1'b0;
        s  = 33'd0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd6: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd7:  r = {31'd0, ($signed(a) < $signed(b))};
            4'd12: r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), co, ov, r};
    endfunction

    always_comb begin
        {alu_zero, alu_cout, alu_overflow, alu_result} = alu_ref(alu_src1, alu_src2, alu_ctrl);
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [31:0] res;
        logic [2:0]  zcv;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  zcv;
        logic [3:0]  c;
    } exp_t;

    vec_t  vec [12];
    exp_t  exp_q [$];
    int    tests;
    int    fails;
    int    pushed_n;
    int    consumed_n;
    int    max_cnt;
    logic  stall_pend;
    logic [31:0] held_res;
    logic [2:0]  held_zcv;
    logic [3:0]  held_ctrl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of scoreboard-driven stimulus; handshakes are evaluated before the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic ordy, input logic r);
        exp_t e;
        logic [34:0] ref_v;
        @(negedge clk);
        if (stall_pend) begin
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_result", {32'd0, out_result}, {32'd0, held_res});
            check("stall_zcv", {61'd0, out_zcv}, {61'd0, held_zcv});
            check("stall_ctrl", {60'd0, out_ctrl}, {60'd0, held_ctrl});
        end
        in_valid  = v;
        in_src1   = a;
        in_src2   = b;
        in_ctrl   = c;
        out_ready = ordy;
        rst       = r;
        #1;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (r) begin
            check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        end else begin
            if (in_valid && in_ready) begin
                ref_v = alu_ref(a, b, c);
                e.res = ref_v[31:0];
                e.zcv = ref_v[34:32];
                e.c   = c;
                exp_q.push_back(e);
                pushed_n++;
            end
            if (out_valid && out_ready) begin
                consumed_n++;
                if (exp_q.size() == 0) begin
                    check("sb_extra_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", {32'd0, out_result}, {32'd0, e.res});
                    check("sb_zcv", {61'd0, out_zcv}, {61'd0, e.zcv});
                    check("sb_ctrl", {60'd0, out_ctrl}, {60'd0, e.c});
                end
            end
        end
        stall_pend = !r && out_valid && !out_ready;
        held_res   = out_result;
        held_zcv   = out_zcv;
        held_ctrl  = out_ctrl;
        @(posedge clk);
        if (r) exp_q.delete();
    endtask

    function automatic logic [3:0] rand_ctrl();
        logic [3:0] codes [6];
        codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2;
        codes[3] = 4'd6; codes[4] = 4'd7; codes[5] = 4'd12;
        return codes[$urandom_range(0, 5)];
    endfunction

    int ord [5];
    int cyc;

    initial begin
        tests = 0; fails = 0; pushed_n = 0; consumed_n = 0; max_cnt = 0;
        stall_pend = 1'b0;
        held_res = 32'd0; held_zcv = 3'd0; held_ctrl = 4'd0;
        rst = 1'b1; in_valid = 1'b0; in_src1 = 32'd0; in_src2 = 32'd0;
        in_ctrl = 4'd0; out_ready = 1'b0;

        vec[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'd2,  32'h80000000, 3'b001};
        vec[1]  = '{32'h12345678, 32'h12345678, 4'd6,  32'h00000000, 3'b110};
        vec[2]  = '{32'hF0F0F0F0, 32'hFF00FF00, 4'd0,  32'hF000F000, 3'b000};
        vec[3]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, 4'd1,  32'hFFFFFFFF, 3'b000};
        vec[4]  = '{32'h00000000, 32'h00000000, 4'd12, 32'hFFFFFFFF, 3'b000};
        vec[5]  = '{32'hFFFFFFFF, 32'h00000000, 4'd12, 32'h00000000, 3'b100};
        vec[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'd2,  32'h00000000, 3'b110};
        vec[7]  = '{32'hFFFFFFFF, 32'h00000001, 4'd7,  32'h00000001, 3'b000};
        vec[8]  = '{32'h00000005, 32'h00000003, 4'd7,  32'h00000000, 3'b100};
        vec[9]  = '{32'h80000000, 32'h00000001, 4'd6,  32'h7FFFFFFF, 3'b011};
        vec[10] = '{32'h00000001, 32'h00000002, 4'd6,  32'hFFFFFFFF, 3'b000};
        vec[11] = '{32'h80000000, 32'h80000000, 4'd2,  32'h00000000, 3'b111};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("rst_count", {61'd0, count}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", {32'd0, out_result}, 64'd0);
        check("rst_out_zcv", {61'd0, out_zcv}, 64'd0);
        check("rst_out_ctrl", {60'd0, out_ctrl}, 64'd0);
        check("rst_alu_src1", {32'd0, alu_src1}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Table of single ops: head visible one cycle after accept, result the next.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_src1 = vec[i].a; in_src2 = vec[i].b; in_ctrl = vec[i].c;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("vec_head_count", {61'd0, count}, 64'd1);
            check("vec_head_src1", {32'd0, alu_src1}, {32'd0, vec[i].a});
            check("vec_head_ctrl", {60'd0, alu_ctrl}, {60'd0, vec[i].c});
            @(posedge clk);
            @(negedge clk);
            check("vec_out_valid", {63'd0, out_valid}, 64'd1);
            check("vec_out_result", {32'd0, out_result}, {32'd0, vec[i].res});
            check("vec_out_zcv", {61'd0, out_zcv}, {61'd0, vec[i].zcv});
            check("vec_out_ctrl", {60'd0, out_ctrl}, {60'd0, vec[i].c});
            check("vec_count_empty", {61'd0, count}, 64'd0);
        end

        // Fill while stalled: AND, OR, ADD, SUB, NOR.
        ord[0] = 2; ord[1] = 3; ord[2] = 0; ord[3] = 1; ord[4] = 4;
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_src1 = vec[ord[k]].a; in_src2 = vec[ord[k]].b; in_ctrl = vec[ord[k]].c;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("full_count", {61'd0, count}, 64'd4);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_out_valid", {63'd0, out_valid}, 64'd1);
        check("full_head_result", {32'd0, out_result}, {32'd0, vec[2].res});
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_result", {32'd0, out_result}, {32'd0, vec[2].res});
            check("hold_ctrl", {60'd0, out_ctrl}, 64'd0);
            check("hold_count", {61'd0, count}, 64'd4);
        end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("drain_result", {32'd0, out_result}, {32'd0, vec[ord[k]].res});
            check("drain_zcv", {61'd0, out_zcv}, {61'd0, vec[ord[k]].zcv});
            check("drain_ctrl", {60'd0, out_ctrl}, {60'd0, vec[ord[k]].c});
            check("drain_count", {61'd0, count}, 64'(4 - k));
            if (k == 1) check("drain_in_ready", {63'd0, in_ready}, 64'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check("drain_done_valid", {63'd0, out_valid}, 64'd0);

        // Streaming: 16 ops back to back, all retired by the 17th capture edge.
        stall_pend = 1'b0; pushed_n = 0; consumed_n = 0; max_cnt = 0;
        for (int k = 0; k < 17; k++) begin
            step(k < 16, $urandom, $urandom, rand_ctrl(), 1'b1, 1'b0);
        end
        check("stream_consumed_17", 64'(consumed_n), 64'd15);
        step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("stream_consumed_18", 64'(consumed_n), 64'd16);
        check("stream_pushed", 64'(pushed_n), 64'd16);
        check("stream_max_count", 64'(max_cnt <= 1), 64'd1);

        // Reset mid-operation with count=3 and a pending result.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, $urandom, $urandom, rand_ctrl(), 1'b0, 1'b0);
        end
        #1;
        check("pre_rst_count", {61'd0, count}, 64'd3);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        step(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
        #1;
        check("mid_rst_count", {61'd0, count}, 64'd0);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_alu", {28'd0, alu_src1 | alu_src2, alu_ctrl}, 64'd0);
        consumed_n = 0;
        step(1'b1, 32'd10, 32'd3, 4'd6, 1'b1, 1'b0);
        step(1'b1, 32'd4, 32'd9, 4'd2, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
        check("post_rst_consumed", 64'(consumed_n), 64'd2);
        check("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random handshake toggling over 200 ops.
        pushed_n = 0; consumed_n = 0; max_cnt = 0; cyc = 0;
        while ((consumed_n < 200) && (cyc < 5000)) begin
            step((pushed_n < 200) && ($urandom_range(0, 1) == 1), $urandom, $urandom,
                 rand_ctrl(), ($urandom_range(0, 1) == 1), 1'b0);
            cyc++;
        end
        check("rand_pushed", 64'(pushed_n), 64'd200);
        check("rand_consumed", 64'(consumed_n), 64'd200);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand_max_count", 64'(max_cnt <= 4), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
